// File: rtl/hash_table_pkg.sv
// Shared hash-table definitions: data-table address width and pointer type.
package hash_table;

    localparam int TABLE_ADDR_WIDTH = 8;

    typedef logic [TABLE_ADDR_WIDTH-1:0] ht_empty_ptr_t;

endpackage

// File: rtl/ht_ptr_fifo.sv
// Pointer FIFO with synchronous write and show-ahead read; the head is visible
// one cycle after it was written. Shared by the empty-pointer and delete paths.
module ht_ptr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign rd_data_o = mem_q[rd_ptr_q];
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset so it maps onto RAM; validity lives in count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/empty_ptr_storage.sv
// Free-address allocator: offers one empty data-RAM address at a time, preferring
// recycled addresses over never-used ones from a fresh counter.
module empty_ptr_storage
    import hash_table::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] add_empty_ptr_i,
    input  logic               add_empty_ptr_en_i,
    output logic [A_WIDTH-1:0] next_empty_ptr_o,
    output logic               next_empty_ptr_val_o,
    input  logic               next_empty_ptr_rd_ack_i,
    output logic [A_WIDTH:0]   empty_cnt_o,
    output logic               overflow_o
);

    typedef enum logic {
        LOAD_S = 1'b0,
        HOLD_S = 1'b1
    } state_t;

    localparam int               DEPTH = 1 << A_WIDTH;
    localparam logic [A_WIDTH:0] N_CNT = {1'b1, {A_WIDTH{1'b0}}};

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] offer_q, offer_d;
    logic               val_q, val_d;
    logic [A_WIDTH:0]   fresh_cnt_q, fresh_cnt_d;
    logic [A_WIDTH:0]   empty_cnt_q, empty_cnt_d;
    logic               overflow_q, overflow_d;

    logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [A_WIDTH-1:0] fifo_head;
    logic               add_acc, ack_acc;

    ht_ptr_fifo #(
        .WIDTH (A_WIDTH),
        .DEPTH (DEPTH)
    ) u_recycle_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (fifo_push),
        .wr_data_i (add_empty_ptr_i),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // The free count bounds FIFO occupancy, so the full term never drops a legal add.
    assign add_acc   = add_empty_ptr_en_i && (empty_cnt_q < N_CNT) && !fifo_full;
    assign ack_acc   = (state_q == HOLD_S) && next_empty_ptr_rd_ack_i;
    assign fifo_push = add_acc;

    always_comb begin
        state_d     = state_q;
        offer_d     = offer_q;
        fresh_cnt_d = fresh_cnt_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            LOAD_S: begin
                if (!fifo_empty) begin
                    offer_d  = fifo_head;
                    fifo_pop = 1'b1;
                    state_d  = HOLD_S;
                end else if (fresh_cnt_q < N_CNT) begin
                    offer_d     = fresh_cnt_q[A_WIDTH-1:0];
                    fresh_cnt_d = fresh_cnt_q + (A_WIDTH+1)'(1);
                    state_d     = HOLD_S;
                end
            end
            HOLD_S: begin
                if (next_empty_ptr_rd_ack_i) begin
                    state_d = LOAD_S;
                end
            end
            default: state_d = LOAD_S;
        endcase
        val_d = (state_d == HOLD_S);

        unique case ({add_acc, ack_acc})
            2'b10:   empty_cnt_d = empty_cnt_q + (A_WIDTH+1)'(1);
            2'b01:   empty_cnt_d = empty_cnt_q - (A_WIDTH+1)'(1);
            default: empty_cnt_d = empty_cnt_q;
        endcase
        overflow_d = overflow_q || (add_empty_ptr_en_i && (empty_cnt_q == N_CNT));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LOAD_S;
            offer_q     <= '0;
            val_q       <= 1'b0;
            fresh_cnt_q <= '0;
            empty_cnt_q <= N_CNT;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            offer_q     <= offer_d;
            val_q       <= val_d;
            fresh_cnt_q <= fresh_cnt_d;
            empty_cnt_q <= empty_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign next_empty_ptr_o     = offer_q;
    assign next_empty_ptr_val_o = val_q;
    assign empty_cnt_o          = empty_cnt_q;
    assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_empty_ptr_storage.sv
// Bench for empty_ptr_storage (A_WIDTH=3): directed vector table, hand sequences,
// then random traffic against a free-pool reference model.
module tb_empty_ptr_storage;

    localparam int AW = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] add_ptr = '0;
    logic          add_en = 1'b0;
    logic          ack = 1'b0;
    logic [AW-1:0] ptr;
    logic          val;
    logic [AW:0]   cnt;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    empty_ptr_storage #(.A_WIDTH(AW)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst_i),
        .add_empty_ptr_i         (add_ptr),
        .add_empty_ptr_en_i      (add_en),
        .next_empty_ptr_o        (ptr),
        .next_empty_ptr_val_o    (val),
        .next_empty_ptr_rd_ack_i (ack),
        .empty_cnt_o             (cnt),
        .overflow_o              (ovf)
    );

    // Reference model: the free pool is recycled queue + unused fresh addresses + offer.
    logic [AW-1:0] m_q[$];
    int            m_fresh = 0;
    bit            m_hold = 1'b0;
    int            m_offer = 0;
    bit            m_ovf = 1'b0;

    function automatic int m_cnt();
        return m_q.size() + (N - m_fresh) + (m_hold ? 1 : 0);
    endfunction

    task automatic model_edge(input bit r, input bit ae, input logic [AW-1:0] a, input bit k);
        bit add_ok;
        if (r) begin
            m_q.delete();
            m_fresh = 0;
            m_hold  = 1'b0;
            m_offer = 0;
            m_ovf   = 1'b0;
        end else begin
            add_ok = ae && (m_cnt() < N);
            if (ae && !add_ok) m_ovf = 1'b1;
            if (m_hold) begin
                if (k) m_hold = 1'b0;
            end else if (m_q.size() > 0) begin
                m_offer = int'(m_q.pop_front());
                m_hold  = 1'b1;
            end else if (m_fresh < N) begin
                m_offer = m_fresh;
                m_fresh++;
                m_hold  = 1'b1;
            end
            if (add_ok) m_q.push_back(a);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit ae, input int a, input bit k);
        @(negedge clk);
        rst_i   = r;
        add_en  = ae;
        add_ptr = AW'(a);
        ack     = k;
        @(posedge clk);
        model_edge(r, ae, AW'(a), k);
        #1;
        $display("t=%0t rst=%0b add=%0b/%0d ack=%0b -> val=%0b ptr=%0d cnt=%0d ovf=%0b",
                 $time, r, ae, a, k, val, ptr, cnt, ovf);
    endtask

    task automatic expect_out(input string tag, input bit ev, input int ep, input int ec, input bit eo);
        check({tag, " val"}, 32'(val), 32'(ev));
        if (ev) check({tag, " ptr"}, 32'(ptr), 32'(ep));
        check({tag, " cnt"}, 32'(cnt), 32'(ec));
        check({tag, " ovf"}, 32'(ovf), 32'(eo));
    endtask

    typedef struct {
        bit rst;
        bit add_en;
        int addr;
        bit ack;
        bit e_val;
        int e_ptr;
        int e_cnt;
        bit e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(bit r, bit ae, int a, bit k, bit ev, int ep, int ec, bit eo);
        vec_t x;
        x.rst = r; x.add_en = ae; x.addr = a; x.ack = k;
        x.e_val = ev; x.e_ptr = ep; x.e_cnt = ec; x.e_ovf = eo;
        vecs.push_back(x);
    endfunction

    initial begin
        // Reset, fresh sequence 0..7 with one low cycle between offers, exhaustion.
        v(1, 0, 0, 0, 0, 0, 8, 0);
        v(0, 0, 0, 0, 1, 0, 8, 0);
        for (int i = 0; i < N; i++) begin
            v(0, 0, 0, 1, 0, 0, 7 - i, 0);
            if (i < N - 1) v(0, 0, 0, 0, 1, i + 1, 7 - i, 0);
            else           v(0, 0, 0, 0, 0, 0, 0, 0);
        end
        v(0, 0, 0, 0, 0, 0, 0, 0);
        // Refill while full-idle: add at t, valid at t+2.
        v(0, 1, 5, 0, 0, 0, 1, 0);
        v(0, 0, 0, 0, 1, 5, 1, 0);
        v(0, 0, 0, 1, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0);
        // Overflow on add at cnt==N, sticky; ack during LOAD ignored.
        v(1, 0, 0, 0, 0, 0, 8, 0);
        v(0, 1, 3, 0, 1, 0, 8, 1);
        v(0, 0, 0, 0, 1, 0, 8, 1);
        v(0, 0, 0, 1, 0, 0, 7, 1);
        v(0, 0, 0, 1, 1, 1, 7, 1);
        v(0, 0, 0, 0, 1, 1, 7, 1);
        v(1, 0, 0, 0, 0, 0, 8, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].add_en, vecs[i].addr, vecs[i].ack);
            check($sformatf("row%0d val", i), 32'(val), 32'(vecs[i].e_val));
            if (vecs[i].e_val || vecs[i].rst)
                check($sformatf("row%0d ptr", i), 32'(ptr), 32'(vecs[i].e_ptr));
            check($sformatf("row%0d cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
            check($sformatf("row%0d ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
        end

        // Priority and offer stability.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        expect_out("prio held3", 1, 3, 5, 0);
        step(0, 1, 6, 0);
        expect_out("prio add6", 1, 3, 6, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        expect_out("prio stable", 1, 3, 6, 0);
        step(0, 0, 0, 1);
        expect_out("prio ack gap", 0, 0, 5, 0);
        step(0, 0, 0, 0);
        expect_out("prio recycled6", 1, 6, 5, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_out("prio fresh4", 1, 4, 4, 0);

        // Simultaneous add and ack.
        step(0, 1, 2, 0);
        expect_out("simul pre", 1, 4, 5, 0);
        step(0, 1, 1, 1);
        expect_out("simul same", 0, 0, 5, 0);
        step(0, 0, 0, 0);
        expect_out("simul head2", 1, 2, 5, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_out("simul then1", 1, 1, 4, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_out("simul fresh5", 1, 5, 3, 0);

        // Reset mid-operation.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        expect_out("mid pre", 1, 4, 6, 0);
        step(1, 0, 0, 0);
        expect_out("mid reset", 0, 0, 8, 0);
        step(0, 0, 0, 0);
        expect_out("mid first0", 1, 0, 8, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_out("mid fifo gone", 1, 1, 7, 0);

        // Random traffic against the reference model.
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit r, ae, k;
            int a;
            r  = ($urandom_range(63) == 0);
            ae = ($urandom_range(2) == 0);
            k  = ($urandom_range(1) == 0);
            a  = int'($urandom_range(N - 1));
            step(r, ae, a, k);
            check($sformatf("rand%0d val", i), 32'(val), 32'(m_hold));
            if (m_hold) check($sformatf("rand%0d ptr", i), 32'(ptr), 32'(m_offer));
            check($sformatf("rand%0d cnt", i), 32'(cnt), 32'(m_cnt()));
            check($sformatf("rand%0d ovf", i), 32'(ovf), 32'(m_ovf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
